// File: rtl/square_add_seq_if.sv
// Request/result bundle for square_add_seq: operand, addend and start pulse toward the unit,
// result, done pulse and busy flag back from it.
// Ports: REQ_i start pulse, DATs_i operand x, ADDs_i addend r, QQs_o x*x+r, DONE_o result pulse, BUSY_o in progress.
interface square_add_seq_if #(
  parameter int C_W = 8
);
  logic             REQ_i;
  logic [C_W-1:0]   DATs_i;
  logic [C_W:0]     ADDs_i;
  logic [2*C_W-1:0] QQs_o;
  logic             DONE_o;
  logic             BUSY_o;

  // master: the requester; slave: the arithmetic unit
  modport master (
    output REQ_i, DATs_i, ADDs_i,
    input  QQs_o, DONE_o, BUSY_o
  );

  modport slave (
    input  REQ_i, DATs_i, ADDs_i,
    output QQs_o, DONE_o, BUSY_o
  );
endinterface

// File: rtl/square_add_seq.sv
// Sequential square-and-add: QQs_o = DATs_i*DATs_i + ADDs_i, one shift-add step per clock.
// Latency C_W+1 cycles from REQ_i to DONE_o; throughput one result per C_W+2 cycles.
// No backpressure: REQ_i at any time aborts and restarts; QQs_o holds until the next DONE_o.
// Ports: CK_i clock, RST_i sync active-high reset, bus (slave modport) carries REQ/operands/result/DONE/BUSY.
module square_add_seq #(
  parameter int C_W = 8
) (
  input  logic             CK_i,
  input  logic             RST_i,
  square_add_seq_if.slave  bus
);

  localparam int CTR_W = $clog2(C_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2*C_W-1:0]  mcand;
  logic [2*C_W-1:0]  acc;
  logic [2*C_W-1:0]  qq;
  logic [C_W-1:0]    mplier;
  logic [CTR_W-1:0]  ctr;
  logic              done;
  logic              busy;
  logic              done_nxt;
  logic              busy_nxt;
  logic              load;
  logic              step;
  logic              last_step;

  // ctr still holds the pre-increment count, so C_W-1 marks the C_W-th (final) RUN step
  assign last_step = (ctr == CTR_W'(C_W - 1));

  // Next-state logic: a request reloads from any state, including FIN
  always_comb begin
    state_nxt = state;
    if (bus.REQ_i) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     state_nxt = last_step ? FIN : RUN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath control; a reload in FIN suppresses the completion
  always_comb begin
    load     = bus.REQ_i;
    step     = (state == RUN) && !bus.REQ_i;
    done_nxt = (state == FIN) && !bus.REQ_i;
    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state  <= IDLE;
      ctr    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      qq     <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      if (load) begin
        mcand  <= {{C_W{1'b0}}, bus.DATs_i};
        mplier <= bus.DATs_i;
        acc    <= {{(C_W-1){1'b0}}, bus.ADDs_i};
        ctr    <= '0;
      end else if (step) begin
        // sum wraps modulo 2^(2*C_W) for out-of-range addends
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        ctr    <= ctr + CTR_W'(1);
      end
      if (done_nxt) begin
        qq <= acc;
      end
    end
  end

  assign bus.QQs_o  = qq;
  assign bus.DONE_o = done;
  assign bus.BUSY_o = busy;

endmodule

// File: tb/tb_square_add_seq.sv
// Scoreboard bench for square_add_seq: stimulus pushes expected results, a monitor pops on DONE_o.
// Reference model is plain arithmetic (x*x + r mod 2^16) and an integer square root.
module tb_square_add_seq;

  localparam int C_W = 8;

  typedef struct {
    longint val;
    int     cyc;
    bit     chk_root;
    int     root;
  } exp_t;

  logic ck;
  logic rst;
  int   cyc;
  logic rst_at_edge;
  int   total;
  int   bad;
  int   done_cnt;
  int   busy_run;
  int   last_busy_len;
  bit   hold_ok;
  longint hold_val;
  exp_t exp_q[$];
  exp_t mon_e;

  square_add_seq_if #(.C_W(C_W)) bus ();

  square_add_seq #(.C_W(C_W)) dut (
    .CK_i  (ck),
    .RST_i (rst),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial cyc = 0;
  always @(posedge ck) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  function automatic longint model(input int x, input int r);
    return (longint'(x) * x + r) % (64'd1 << (2 * C_W));
  endfunction

  function automatic int isqrt(input longint v);
    int s = 0;
    while (longint'(s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: reset values, result/latency on DONE_o, value hold between completions
  always @(negedge ck) begin
    if (rst_at_edge === 1'b1) begin
      chk("reset_qq", bus.QQs_o, 0);
      chk("reset_done", bus.DONE_o, 0);
      chk("reset_busy", bus.BUSY_o, 0);
      hold_val = 0;
      hold_ok  = 1'b1;
    end else if (bus.DONE_o === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual QQs_o=%0d required no completion", bus.QQs_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", bus.QQs_o, mon_e.val);
        chk("latency", cyc - mon_e.cyc, C_W + 1);
        if (mon_e.chk_root) chk("round_trip_root", isqrt(bus.QQs_o), mon_e.root);
        hold_val = mon_e.val;
        hold_ok  = 1'b1;
      end
    end else if (hold_ok) begin
      chk("hold", bus.QQs_o, hold_val);
    end
    if (bus.BUSY_o === 1'b1) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
  end

  // Pulse REQ_i for one edge; operands are scrambled right after sampling
  task automatic start(input int x, input int r, input bit expect_done,
                       input bit chk_root = 1'b0, input int root = 0);
    exp_t e;
    bus.DATs_i = C_W'(x);
    bus.ADDs_i = (C_W+1)'(r);
    bus.REQ_i  = 1'b1;
    @(posedge ck);
    #1;
    if (expect_done) begin
      e.val      = model(x, r);
      e.cyc      = cyc;
      e.chk_root = chk_root;
      e.root     = root;
      exp_q.push_back(e);
    end
    bus.REQ_i  = 1'b0;
    bus.DATs_i = C_W'($urandom);
    bus.ADDs_i = (C_W+1)'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge ck);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wait_idle_timeout: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    do begin
      @(negedge ck);
      n++;
    end while (bus.DONE_o !== 1'b1 && n < bound);
    total++;
    if (bus.DONE_o !== 1'b1) begin
      bad++;
      $display("FAIL wait_done_timeout: actual DONE_o=%b required 1", bus.DONE_o);
    end
  endtask

  initial begin
    int d0;
    total = 0; bad = 0; done_cnt = 0; busy_run = 0; last_busy_len = 0;
    hold_ok = 1'b0; hold_val = 0;
    rst = 1'b1;
    bus.REQ_i = 1'b0; bus.DATs_i = '0; bus.ADDs_i = '0;
    repeat (3) @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);

    // zero operand, busy window length
    start(0, 0, 1'b1);
    wait_idle(40);
    repeat (2) @(negedge ck);
    chk("busy_len", last_busy_len, C_W + 1);

    // max operand, then max legal addend without wrap
    start(255, 0, 1'b1);
    wait_idle(40);
    start(255, 510, 1'b1);
    wait_idle(40);

    // operand changes after REQ must not matter (start scrambles them)
    start(13, 5, 1'b1);
    wait_idle(40);

    // abort four cycles in: only the second operation completes
    start(200, 0, 1'b0);
    repeat (3) @(posedge ck);
    #1;
    start(3, 1, 1'b1);
    wait_idle(40);

    // reset mid-run: no completion, result returns to 0
    d0 = done_cnt;
    start(200, 7, 1'b0);
    repeat (4) @(posedge ck);
    #1 rst = 1'b1;
    @(posedge ck);
    #1 rst = 1'b0;
    repeat (20) @(negedge ck);
    chk("reset_no_done", done_cnt, d0);
    chk("reset_qq_after", bus.QQs_o, 0);

    // back-to-back: new REQ in each DONE_o cycle
    start(1, 0, 1'b1);
    for (int n = 2; n <= 20; n++) begin
      wait_done(40);
      start(n, 0, 1'b1);
    end
    wait_idle(40);

    // round trip through an integer square root
    for (int x = 0; x < 256; x++) begin
      start(x, 0, 1'b1, 1'b1, x);
      wait_idle(40);
      start(x, x, 1'b1, 1'b1, x);
      wait_idle(40);
      start(x, 2 * x, 1'b1, 1'b1, x);
      wait_idle(40);
    end

    // random operands (including wrapping addends) with random aborts
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        start($urandom_range(0, 255), $urandom_range(0, 511), 1'b0);
        repeat ($urandom_range(0, C_W)) @(posedge ck);
        #1;
      end
      start($urandom_range(0, 255), $urandom_range(0, 511), 1'b1);
      wait_idle(40);
      repeat ($urandom_range(0, 2)) @(negedge ck);
    end

    repeat (5) @(negedge ck);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
